// File: rtl/ifetch_responder.sv
// IF-stage instruction responder: returns {inst@pc+4, inst@pc} pairs,
// replaying a one-entry pair buffer and filling misses over a req/ack bus.
module ifetch_responder #(
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    input  logic [ADDR_W-1:0]   req_pc_i,
    output logic                req_ready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [2*INSN_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0]   rsp_pc_o,
    input  logic                flush_i,
    input  logic                inval_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [INSN_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic [CNT_W-1:0]    stat_hit_o,
    output logic [CNT_W-1:0]    stat_miss_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD0   = 3'd1;
    localparam logic [2:0] S_RD1   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSN_W-1:0]   r_lo;
    logic                r_inval_pend;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_tag;
    logic [2*INSN_W-1:0] r_buf_data;
    logic                r_rsp_valid;
    logic [2*INSN_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0]   r_rsp_pc;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [CNT_W-1:0]    r_hit;
    logic [CNT_W-1:0]    r_miss;

    logic [ADDR_W-1:0]   w_pc;
    logic                w_accept;
    logic                w_hit;

    assign w_pc        = req_pc_i & ~ADDR_W'(3);
    assign req_ready_o = (r_state == S_IDLE) & ~flush_i;
    assign w_accept    = req_valid_i & req_ready_o;
    // A same-cycle invalidate turns a would-be hit into a miss.
    assign w_hit       = r_buf_valid & (r_buf_tag == w_pc) & ~inval_i;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_pc_o    = r_rsp_pc;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign stat_hit_o  = r_hit;
    assign stat_miss_o = r_miss;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_lo         <= '0;
            r_inval_pend <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= '0;
            r_buf_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_pc     <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hit        <= '0;
            r_miss       <= '0;
        end else begin
            if (inval_i) begin
                r_buf_valid <= 1'b0;
            end
            if (inval_i && (r_state == S_RD0 || r_state == S_RD1)) begin
                r_inval_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pc <= w_pc;
                        if (w_hit) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_buf_data;
                            r_rsp_pc    <= w_pc;
                            if (r_hit != '1) r_hit <= r_hit + 1'b1;
                        end else begin
                            r_state      <= S_RD0;
                            r_mem_req    <= 1'b1;
                            r_mem_addr   <= w_pc;
                            r_inval_pend <= 1'b0;
                            if (r_miss != '1) r_miss <= r_miss + 1'b1;
                        end
                    end
                end
                S_RD0: begin
                    if (flush_i) begin
                        if (mem_ack_i) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_ack_i) begin
                        r_lo       <= mem_rdata_i;
                        r_state    <= S_RD1;
                        r_mem_addr <= r_pc + ADDR_W'(4);
                    end
                end
                S_RD1: begin
                    if (flush_i) begin
                        if (mem_ack_i) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_ack_i) begin
                        r_state     <= S_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {mem_rdata_i, r_lo};
                        r_rsp_pc    <= r_pc;
                        if (!r_inval_pend && !inval_i) begin
                            r_buf_valid <= 1'b1;
                            r_buf_tag   <= r_pc;
                            r_buf_data  <= {mem_rdata_i, r_lo};
                        end
                    end
                end
                S_RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (mem_ack_i) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder with a variable-latency memory responder.
module tb_ifetch_responder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic [31:0] req_pc_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic [31:0] rsp_pc_o;
    logic        flush_i;
    logic        inval_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [15:0] stat_hit_o;
    logic [15:0] stat_miss_o;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int gen = 0;
    int cnt = 0;
    logic [31:0] addr_log[$];

    ifetch_responder dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_pc_i(req_pc_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_pc_o(rsp_pc_o), .flush_i(flush_i), .inval_i(inval_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h100) return 32'hAAAA0001 + gen;
        if (a == 32'h104) return 32'hBBBB0002 + gen;
        return (a ^ 32'h5A5A5A5A) + gen;
    endfunction

    // memory: acks the lat-th negedge a request has been pending
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_req_o && !reset_i) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = memword(mem_addr_o);
                    addr_log.push_back(mem_addr_o);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic send_req(input logic [31:0] pc);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_pc_i    = pc;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_valid_i = 0; req_pc_i = 0;
        rsp_ready_i = 0; flush_i = 0; inval_i = 0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, mem_req_o, rsp_data_o, rsp_pc_o, mem_addr_o,
             stat_hit_o, stat_miss_o} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got v=%b req=%b d=%h pc=%h a=%h h=%0d m=%0d want all 0",
                     rsp_valid_o, mem_req_o, rsp_data_o, rsp_pc_o, mem_addr_o,
                     stat_hit_o, stat_miss_o);
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_miss();
        bit ok;
        lat = 3;
        addr_log.delete();
        send_req(32'h100);
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL miss_timeout: no rsp_valid_o within bound");
        end
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 32'h100 || addr_log[1] !== 32'h104) begin
            errors++;
            $display("FAIL miss_addrs: got n=%0d want 0x100,0x104", addr_log.size());
        end
        checks++;
        if (rsp_data_o !== 64'hBBBB0002_AAAA0001 || rsp_pc_o !== 32'h100) begin
            errors++;
            $display("FAIL miss_data: got %h pc %h want bbbb0002aaaa0001 pc 100",
                     rsp_data_o, rsp_pc_o);
        end
        checks++;
        if (stat_miss_o !== 16'd1 || stat_hit_o !== 16'd0) begin
            errors++;
            $display("FAIL miss_stats: got m=%0d h=%0d want m=1 h=0", stat_miss_o, stat_hit_o);
        end
        consume();
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_consume: got v=%b rdy=%b want v=0 rdy=1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_hit();
        send_req(32'h101);
        checks++;
        if (rsp_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_latency: got v=%b req=%b want v=1 req=0", rsp_valid_o, mem_req_o);
        end
        checks++;
        if (rsp_data_o !== 64'hBBBB0002_AAAA0001 || rsp_pc_o !== 32'h100 || stat_hit_o !== 16'd1) begin
            errors++;
            $display("FAIL hit_data: got %h pc %h h=%0d want bbbb0002aaaa0001 pc 100 h=1",
                     rsp_data_o, rsp_pc_o, stat_hit_o);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        send_req(32'h100);
        req_valid_i = 1'b1;
        req_pc_i    = 32'h300;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
                rsp_data_o !== 64'hBBBB0002_AAAA0001) bad++;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
        end
        checks++;
        if (stat_hit_o !== 16'd2 || stat_miss_o !== 16'd1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stats: got h=%0d m=%0d req=%b want h=2 m=1 req=0",
                     stat_hit_o, stat_miss_o, mem_req_o);
        end
        consume();
    endtask

    task automatic test_flush();
        bit seen;
        bit rv;
        lat = 4;
        send_req(32'h200);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req_o && mem_addr_o == 32'h204) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL flush_rd1: never reached second read");
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: got req=%b rdy=%b want req=1 rdy=0", mem_req_o, req_ready_o);
        end
        seen = 1'b0;
        rv = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid_o) rv = 1'b1;
            if (!mem_req_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        repeat (2) @(negedge clk_i);
        if (rsp_valid_o) rv = 1'b1;
        checks++;
        if (!seen || rv) begin
            errors++;
            $display("FAIL flush_drain: got dropped=%b rsp_seen=%b want 1 0", seen, rv);
        end
        send_req(32'h100);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'hBBBB0002_AAAA0001 || stat_hit_o !== 16'd3) begin
            errors++;
            $display("FAIL flush_hit: got v=%b d=%h h=%0d want 1 bbbb0002aaaa0001 3",
                     rsp_valid_o, rsp_data_o, stat_hit_o);
        end
        consume();
    endtask

    task automatic test_inval_wrap();
        bit ok;
        lat = 2;
        gen = 1;
        inval_i = 1'b1;
        @(negedge clk_i);
        inval_i = 1'b0;
        send_req(32'h100);
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_data_o !== 64'hBBBB0003_AAAA0002 || stat_miss_o !== 16'd3) begin
            errors++;
            $display("FAIL inval_miss: got ok=%b d=%h m=%0d want 1 bbbb0003aaaa0002 3",
                     ok, rsp_data_o, stat_miss_o);
        end
        consume();
        send_req(32'h100);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'hBBBB0003_AAAA0002) begin
            errors++;
            $display("FAIL inval_install: got v=%b d=%h want 1 bbbb0003aaaa0002",
                     rsp_valid_o, rsp_data_o);
        end
        consume();
        addr_log.delete();
        send_req(32'hFFFFFFFE);
        wait_rsp(ok);
        checks++;
        if (!ok || addr_log.size() != 2 || addr_log[0] !== 32'hFFFFFFFC || addr_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addrs: got ok=%b n=%0d want fffffffc then 0", ok, addr_log.size());
        end
        checks++;
        if (rsp_data_o !== 64'h5A5A5A5B_A5A5A5A7 || rsp_pc_o !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL wrap_data: got %h pc %h want 5a5a5a5ba5a5a5a7 pc fffffffc",
                     rsp_data_o, rsp_pc_o);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 10;
        send_req(32'h400);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400) begin
            errors++;
            $display("FAIL rst_pre: got req=%b a=%h want 1 400", mem_req_o, mem_addr_o);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({rsp_valid_o, mem_req_o, rsp_data_o, rsp_pc_o, mem_addr_o,
             stat_hit_o, stat_miss_o} !== '0) begin
            errors++;
            $display("FAIL rst_async: got req=%b a=%h d=%h h=%0d m=%0d want all 0",
                     mem_req_o, mem_addr_o, rsp_data_o, stat_hit_o, stat_miss_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        lat = 2;
        send_req(32'hFFFFFFFC);
        checks++;
        if (rsp_valid_o !== 1'b0 || mem_req_o !== 1'b1 || stat_miss_o !== 16'd1) begin
            errors++;
            $display("FAIL rst_empty: got v=%b req=%b m=%0d want 0 1 1",
                     rsp_valid_o, mem_req_o, stat_miss_o);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_data_o !== 64'h5A5A5A5B_A5A5A5A7) begin
            errors++;
            $display("FAIL rst_refill: got ok=%b d=%h want 1 5a5a5a5ba5a5a5a7", ok, rsp_data_o);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_backpressure();
        test_flush();
        test_inval_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
